// File: rtl/tile_rx_pkg.sv
// Shared definitions for the tile receive arbiter: FSM states, width codes
// and the width / beats-per-tile helpers.
package tile_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BURST     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [1:0] W128     = 2'd0;
  localparam logic [1:0] W256     = 2'd1;
  localparam logic [1:0] W512     = 2'd2;
  localparam logic [1:0] WILLEGAL = 2'd3;

  // Beat width in bits for a width code; 0 for the illegal code.
  function automatic logic [31:0] width_bits(input logic [1:0] code);
    case (code)
      W128:    return 32'd128;
      W256:    return 32'd256;
      W512:    return 32'd512;
      default: return 32'd0;
    endcase
  endfunction

  // Number of beats that make up one tile of 32-bit pixels.
  function automatic int unsigned beats_per_tile(input int unsigned tile_size,
                                                 input logic [1:0]  code);
    logic [31:0] w;
    w = width_bits(code);
    if (w == 32'd0) return 0;
    return (32 * tile_size * tile_size) / w;
  endfunction

endpackage

// File: rtl/tile_rx_arb_if.sv
// Requester / datapath bus of the tile receive arbiter.
// slave: arbiter side, master: requesters plus planar-split datapath.
interface tile_rx_arb_if #(
  parameter int DW = 512
);
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [31:0]   m_width;
  logic          m_src;
  logic          tile_done;

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, tile_done,
    output s0_ready, s1_ready, m_valid, m_data, m_width, m_src
  );

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, tile_done,
    input  s0_ready, s1_ready, m_valid, m_data, m_width, m_src
  );
endinterface

// File: rtl/tile_rx_rr.sv
// Two-way round-robin arbiter. Requester 0 has priority after reset; on a
// conflict the requester not granted last wins. While lock is high no grant
// is issued and the priority pointer holds.
module tile_rx_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic prio;

  // Pick the winner from the current requests and priority pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (!lock && (req != 2'b00)) begin
      gnt_vld = 1'b1;
      if (req == 2'b11) gnt_idx = prio;
      else              gnt_idx = req[1];
    end
  end

  // Hand priority to the other requester after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prio <= 1'b0;
    else if (gnt_vld) prio <= ~gnt_idx;
  end

endmodule

// File: rtl/tile_rx_arb.sv
// Tile receive arbiter: grants one of two requesters for a whole tile,
// forwards its beats with zero latency and waits for tile_done before the
// next grant. Optional feature: TILE_RX_ARB_STATS_EN adds per-requester
// saturating tile counters (tiles0 / tiles1).
module tile_rx_arb
  import tile_rx_pkg::*;
#(
  parameter int TILE_SIZE = 8,
  parameter int DW        = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   cfg_width,
  tile_rx_arb_if.slave bus,
  output logic         cfg_err,
  output logic         busy
`ifdef TILE_RX_ARB_STATS_EN
  ,
  output logic [15:0]  tiles0,
  output logic [15:0]  tiles1
`endif
);

  // Counter wide enough for the largest tile (narrowest beat).
  localparam int CNT_W = $clog2(((32 * TILE_SIZE * TILE_SIZE) / 128) + 2);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            src;
  logic [31:0]     width_q;
  logic [1:0]      req;
  logic            lock;
  logic            gnt_vld;
  logic            gnt_idx;
  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   fwd_data;
  logic            done_ok;

  assign req       = {bus.s1_valid, bus.s0_valid};
  // No grant outside IDLE and never on the illegal width code.
  assign lock      = (state != IDLE) || (cfg_width == WILLEGAL);
  assign sel_valid = src ? bus.s1_valid : bus.s0_valid;
  assign sel_data  = src ? bus.s1_data  : bus.s0_data;
  assign done_ok   = (state == WAIT_DONE) && bus.tile_done;

  tile_rx_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Next-state, beat counter and combinational bus outputs.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;
    bus.m_valid  = 1'b0;
    fwd_data     = '0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nxt = BURST;
          cnt_nxt   = CNT_W'(beats_per_tile(TILE_SIZE, cfg_width));
        end
      end
      BURST: begin
        bus.s0_ready = ~src;
        bus.s1_ready = src;
        bus.m_valid  = sel_valid;
        fwd_data     = sel_data;
        if (sel_valid) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tile_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m_data  = fwd_data;
  assign bus.m_width = width_q;
  assign bus.m_src   = src;
  assign busy        = (state != IDLE);

  // State, count and per-tile latches; cfg_err flags each refused grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      src     <= 1'b0;
      width_q <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (gnt_vld) begin
        src     <= gnt_idx;
        width_q <= width_bits(cfg_width);
      end
      cfg_err <= (state == IDLE) && (|req) && (cfg_width == WILLEGAL);
    end
  end

`ifdef TILE_RX_ARB_STATS_EN
  // Count completed tiles per owning requester, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles0 <= '0;
      tiles1 <= '0;
    end else if (done_ok) begin
      if (!src && (tiles0 != 16'hFFFF)) tiles0 <= tiles0 + 16'd1;
      if ( src && (tiles1 != 16'hFFFF)) tiles1 <= tiles1 + 16'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done_ok;
`endif

endmodule

// File: tb/tb_tile_rx_arb.sv
// Directed bench for tile_rx_arb (TILE_SIZE 8, DW 512). Honours
// TILE_RX_ARB_STATS_EN to also check the tile counters.
module tb_tile_rx_arb;
  import tile_rx_pkg::*;

  localparam int DW = 512;

  logic       clk;
  logic       rst_n;
  logic [1:0] cfg_width;
  logic       cfg_err;
  logic       busy;
`ifdef TILE_RX_ARB_STATS_EN
  logic [15:0] tiles0;
  logic [15:0] tiles1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int c0          = 0;
  int c1          = 0;

  tile_rx_arb_if #(.DW(DW)) bus ();

  tile_rx_arb #(.TILE_SIZE(8), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_width (cfg_width),
    .bus       (bus),
    .cfg_err   (cfg_err),
    .busy      (busy)
`ifdef TILE_RX_ARB_STATS_EN
    ,
    .tiles0    (tiles0),
    .tiles1    (tiles1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of a requester: tagged low word, inverted copy in the top word.
  function automatic logic [DW-1:0] dval(input bit who, input int c);
    logic [DW-1:0] v;
    v = '0;
    v[31:0] = {(who ? 16'hB001 : 16'hA000), c[15:0]};
    v[DW-1 -: 32] = ~v[31:0];
    return v;
  endfunction

  assign bus.s0_data = dval(1'b0, c0);
  assign bus.s1_data = dval(1'b1, c1);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit who, input logic v);
    if (who) bus.s1_valid = v;
    else     bus.s0_valid = v;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_s0_ready"}, bus.s0_ready, 1'b0);
    chk1({tag, "_s1_ready"}, bus.s1_ready, 1'b0);
    chk1({tag, "_m_valid"},  bus.m_valid,  1'b0);
    chkw({tag, "_m_data"},   bus.m_data,   '0);
    chk32({tag, "_m_width"}, bus.m_width,  32'd0);
    chk1({tag, "_m_src"},    bus.m_src,    1'b0);
    chk1({tag, "_busy"},     busy,         1'b0);
    chk1({tag, "_cfg_err"},  cfg_err,      1'b0);
`ifdef TILE_RX_ARB_STATS_EN
    chk16({tag, "_tiles0"}, tiles0, 16'd0);
    chk16({tag, "_tiles1"}, tiles1, 16'd0);
`endif
  endtask

  // Called in an IDLE cycle with a grant pending; checks every beat of the
  // tile, optionally stalling (valid low, stray tile_done, cfg change).
  task automatic do_tile(input bit who, input int n, input logic [31:0] wexp,
                         input int stall_at, input int stall_len);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk1("ready_own",   who ? bus.s1_ready : bus.s0_ready, 1'b1);
      chk1("ready_other", who ? bus.s0_ready : bus.s1_ready, 1'b0);
      chk1("m_valid",     bus.m_valid, 1'b1);
      chkw("m_data",      bus.m_data, dval(who, who ? c1 : c0));
      chk1("m_src",       bus.m_src, who);
      chk32("m_width",    bus.m_width, wexp);
      chk1("cfg_err_burst", cfg_err, 1'b0);
      @(posedge clk); #1;
      if (who) c1++;
      else     c0++;
      if (k + 1 == stall_at) begin
        set_valid(who, 1'b0);
        bus.tile_done = 1'b1;
        cfg_width = W512;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clk);
          chk1("stall_m_valid", bus.m_valid, 1'b0);
          chk1("stall_busy",    busy, 1'b1);
          chk1("stall_ready",   who ? bus.s1_ready : bus.s0_ready, 1'b1);
          chk1("stall_m_src",   bus.m_src, who);
          @(posedge clk); #1;
          bus.tile_done = 1'b0;
        end
        set_valid(who, 1'b1);
      end
    end
    @(negedge clk);
    chk1("wait_busy",     busy, 1'b1);
    chk1("wait_s0_ready", bus.s0_ready, 1'b0);
    chk1("wait_s1_ready", bus.s1_ready, 1'b0);
    chk1("wait_m_valid",  bus.m_valid, 1'b0);
  endtask

  // Pulse tile_done in WAIT_DONE; the following cycle must be IDLE.
  task automatic finish_tile();
    @(posedge clk); #1;
    bus.tile_done = 1'b1;
    @(posedge clk); #1;
    bus.tile_done = 1'b0;
    @(negedge clk);
    chk1("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cfg_width     = W128;
    bus.s0_valid  = 1'b0;
    bus.s1_valid  = 1'b0;
    bus.tile_done = 1'b0;
    #3;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 512-bit tile from s0 streaming continuously.
    cfg_width    = W512;
    bus.s0_valid = 1'b1;
    @(negedge clk);
    chk1("idle_busy",  busy, 1'b0);
    chk1("idle_ready", bus.s0_ready, 1'b0);
    do_tile(1'b0, 4, 32'd512, -1, 0);
    bus.s0_valid = 1'b0;
    finish_tile();

    // Fresh reset, both requesters valid at 128 bits: s0, s1, s0.
    rst_n = 1'b0;
    #1;
    check_zero("reset2");
    @(posedge clk); #1;
    rst_n        = 1'b1;
    cfg_width    = W128;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    do_tile(1'b0, 16, 32'd128, -1, 0);
    finish_tile();
    do_tile(1'b1, 16, 32'd128, -1, 0);
    finish_tile();
    do_tile(1'b0, 16, 32'd128, -1, 0);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    finish_tile();

    // 256-bit tile from s1 with a 5-cycle stall after beat 3.
    cfg_width    = W256;
    bus.s1_valid = 1'b1;
    do_tile(1'b1, 8, 32'd256, 3, 5);
    bus.s1_valid = 1'b0;
    finish_tile();
`ifdef TILE_RX_ARB_STATS_EN
    chk16("stats_mid_tiles0", tiles0, 16'd2);
    chk16("stats_mid_tiles1", tiles1, 16'd2);
`endif

    // Illegal width: cfg_err every cycle, no grant; then a legal width.
    cfg_width    = WILLEGAL;
    bus.s0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("illegal_cfg_err", cfg_err, 1'b1);
      chk1("illegal_ready",   bus.s0_ready, 1'b0);
      chk1("illegal_busy",    busy, 1'b0);
    end
    @(posedge clk); #1;
    cfg_width = W256;
    do_tile(1'b0, 8, 32'd256, -1, 0);
    bus.s0_valid = 1'b0;
    finish_tile();
`ifdef TILE_RX_ARB_STATS_EN
    chk16("stats_tiles0", tiles0, 16'd3);
    chk16("stats_tiles1", tiles1, 16'd2);
`endif

    // Stray tile_done in IDLE has no effect.
    @(posedge clk); #1;
    bus.tile_done = 1'b1;
    @(posedge clk); #1;
    bus.tile_done = 1'b0;
    @(negedge clk);
    chk1("stray_busy", busy, 1'b0);
`ifdef TILE_RX_ARB_STATS_EN
    chk16("stray_tiles0", tiles0, 16'd3);
    chk16("stray_tiles1", tiles1, 16'd2);
`endif

    // Reset after beat 2 of a 512-bit tile, then a clean tile from s0.
    @(posedge clk); #1;
    cfg_width    = W512;
    bus.s0_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("pre_rst_busy", busy, 1'b1);
    @(posedge clk); #1;
    c0++;
    @(posedge clk); #1;
    c0++;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_tile(1'b0, 4, 32'd512, -1, 0);
    bus.s0_valid = 1'b0;
    finish_tile();
`ifdef TILE_RX_ARB_STATS_EN
    chk16("post_rst_tiles0", tiles0, 16'd1);
    chk16("post_rst_tiles1", tiles1, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
